// File: rtl/mem_bus_bridge_if.sv
// CPU-side data bus between the MMU wrapper (master) and the bridge (slave).
// db_accessType encodings: 0 = NONE, 1 = R, 2 = W, 3 = X.
interface mem_bus_bridge_if;
  logic [31:0] db_addr;
  logic [31:0] db_dataOut;
  logic [1:0]  db_accessType;
  logic [31:0] db_dataIn;
  logic        db_ready;

  modport master (
    output db_addr, db_dataOut, db_accessType,
    input  db_dataIn, db_ready
  );

  modport slave (
    input  db_addr, db_dataOut, db_accessType,
    output db_dataIn, db_ready
  );
endinterface

// File: rtl/mem_bus_bridge.sv
// Physical-bus slave: decodes one db_* request at a time into a synchronous
// RAM access, a req/ack MMIO access or an error, and returns a one-cycle
// db_ready pulse with registered read data.
module mem_bus_bridge #(
  parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
  parameter int          RAM_AW_LOG2 = 16,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000,
  parameter int          IO_AW_LOG2  = 12,
  parameter int          RAM_LAT     = 1,
  parameter int          IO_TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   res,
  mem_bus_bridge_if.slave        db,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [RAM_AW_LOG2-3:0] ram_addr,
  output logic [31:0]            ram_wdata,
  input  logic [31:0]            ram_rdata,
  output logic                   io_req,
  output logic                   io_we,
  output logic [IO_AW_LOG2-1:0]  io_addr,
  output logic [31:0]            io_wdata,
  input  logic [31:0]            io_rdata,
  input  logic                   io_ack,
  output logic                   bus_err,
  output logic [31:0]            err_addr
);

  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_W    = 2'd2;
  localparam logic [1:0] ACC_X    = 2'd3;

  localparam int CNT_MAX = (RAM_LAT > IO_TIMEOUT) ? RAM_LAT : IO_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [31:0] RAM_MASK = ~((32'd1 << RAM_AW_LOG2) - 32'd1);
  localparam logic [31:0] IO_MASK  = ~((32'd1 << IO_AW_LOG2) - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_RAM, S_IO, S_RESP} state_t;

  state_t                r_state, nxt_state;
  logic [CNT_W-1:0]      r_cnt, nxt_cnt;
  logic                  r_is_wr, nxt_is_wr;
  logic [31:0]           r_addr, nxt_addr;
  logic [31:0]           r_data_in, nxt_data_in;
  logic                  r_ready, nxt_ready;
  logic                  r_bus_err, nxt_bus_err;
  logic [31:0]           r_err_addr, nxt_err_addr;
  logic                  r_io_req, nxt_io_req;
  logic                  r_io_we, nxt_io_we;
  logic [IO_AW_LOG2-1:0] r_io_addr, nxt_io_addr;
  logic [31:0]           r_io_wdata, nxt_io_wdata;

  logic        w_req, w_aligned, w_ram_hit, w_io_hit, w_is_wr;
  logic        w_ram_en, w_err;
  logic [31:0] w_err_addr_src;

  // Request decode, evaluated on the live bus while idle
  assign w_req     = (db.db_accessType != ACC_NONE);
  assign w_is_wr   = (db.db_accessType == ACC_W);
  assign w_aligned = (db.db_addr[1:0] == 2'b00);
  assign w_ram_hit = ((db.db_addr & RAM_MASK) == RAM_BASE);
  assign w_io_hit  = ((db.db_addr & IO_MASK) == IO_BASE);

  // The RAM strobe is issued in the same cycle the request is seen so that
  // read data is valid RAM_LAT cycles later and the response lands at RAM_LAT+1.
  assign ram_en    = w_ram_en;
  assign ram_we    = w_ram_en & w_is_wr;
  assign ram_addr  = db.db_addr[RAM_AW_LOG2-1:2];
  assign ram_wdata = db.db_dataOut;

  assign io_req    = r_io_req;
  assign io_we     = r_io_we;
  assign io_addr   = r_io_addr;
  assign io_wdata  = r_io_wdata;

  assign bus_err      = r_bus_err;
  assign err_addr     = r_err_addr;
  assign db.db_dataIn = r_data_in;
  assign db.db_ready  = r_ready;

  // Next-state and next-register computation; all error paths funnel into one completion block
  always_comb begin
    nxt_state      = r_state;
    nxt_cnt        = r_cnt;
    nxt_is_wr      = r_is_wr;
    nxt_addr       = r_addr;
    nxt_data_in    = r_data_in;
    nxt_ready      = 1'b0;
    nxt_bus_err    = r_bus_err;
    nxt_err_addr   = r_err_addr;
    nxt_io_req     = r_io_req;
    nxt_io_we      = r_io_we;
    nxt_io_addr    = r_io_addr;
    nxt_io_wdata   = r_io_wdata;
    w_ram_en       = 1'b0;
    w_err          = 1'b0;
    w_err_addr_src = r_addr;

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          nxt_addr  = db.db_addr;
          nxt_is_wr = w_is_wr;
          if (!w_aligned) begin
            w_err          = 1'b1;
            w_err_addr_src = db.db_addr;
          end else if (w_ram_hit) begin
            w_ram_en  = 1'b1;
            nxt_cnt   = CNT_W'(RAM_LAT);
            nxt_state = S_RAM;
          end else if (w_io_hit && (db.db_accessType != ACC_X)) begin
            nxt_io_req   = 1'b1;
            nxt_io_we    = w_is_wr;
            nxt_io_addr  = db.db_addr[IO_AW_LOG2-1:0];
            nxt_io_wdata = db.db_dataOut;
            nxt_cnt      = CNT_W'(IO_TIMEOUT);
            nxt_state    = S_IO;
          end else begin
            // X into MMIO space, or no window matched
            w_err          = 1'b1;
            w_err_addr_src = db.db_addr;
          end
        end
      end

      S_RAM: begin
        if (r_cnt == CNT_W'(1)) begin
          // Writes leave the returned data untouched
          if (!r_is_wr) nxt_data_in = ram_rdata;
          nxt_state = S_RESP;
          nxt_ready = 1'b1;
        end else begin
          nxt_cnt = r_cnt - CNT_W'(1);
        end
      end

      S_IO: begin
        // An ack coinciding with the last timeout cycle still completes normally
        if (io_ack) begin
          nxt_io_req = 1'b0;
          nxt_io_we  = 1'b0;
          if (!r_is_wr) nxt_data_in = io_rdata;
          nxt_state  = S_RESP;
          nxt_ready  = 1'b1;
        end else if (r_cnt == CNT_W'(1)) begin
          nxt_io_req = 1'b0;
          nxt_io_we  = 1'b0;
          w_err      = 1'b1;
        end else begin
          nxt_cnt = r_cnt - CNT_W'(1);
        end
      end

      S_RESP: nxt_state = S_IDLE;

      default: nxt_state = S_IDLE;
    endcase

    // Error completion: zero data, sticky flag, first offending address only
    if (w_err) begin
      nxt_data_in = '0;
      nxt_bus_err = 1'b1;
      if (!r_bus_err) nxt_err_addr = w_err_addr_src;
      nxt_state   = S_RESP;
      nxt_ready   = 1'b1;
    end
  end

  // State and datapath registers; reset clears everything including a live io_req
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_wr    <= 1'b0;
      r_addr     <= '0;
      r_data_in  <= '0;
      r_ready    <= 1'b0;
      r_bus_err  <= 1'b0;
      r_err_addr <= '0;
      r_io_req   <= 1'b0;
      r_io_we    <= 1'b0;
      r_io_addr  <= '0;
      r_io_wdata <= '0;
    end else begin
      r_state    <= nxt_state;
      r_cnt      <= nxt_cnt;
      r_is_wr    <= nxt_is_wr;
      r_addr     <= nxt_addr;
      r_data_in  <= nxt_data_in;
      r_ready    <= nxt_ready;
      r_bus_err  <= nxt_bus_err;
      r_err_addr <= nxt_err_addr;
      r_io_req   <= nxt_io_req;
      r_io_we    <= nxt_io_we;
      r_io_addr  <= nxt_io_addr;
      r_io_wdata <= nxt_io_wdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Bench for mem_bus_bridge: directed cases followed by random accesses,
// each checked against an address-map/timing model of the bridge.
module tb_mem_bus_bridge;

  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_R    = 2'd1;
  localparam logic [1:0] ACC_W    = 2'd2;
  localparam logic [1:0] ACC_X    = 2'd3;
  localparam int         TMO      = 8;

  logic        clk = 1'b0;
  logic        res;
  logic        ram_en, ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        io_req, io_we;
  logic [11:0] io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic        io_ack;
  logic        bus_err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_bridge_if bus ();

  mem_bus_bridge #(
    .RAM_LAT   (1),
    .IO_TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .res      (res),
    .db       (bus.slave),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .io_req   (io_req),
    .io_we    (io_we),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_ack   (io_ack),
    .bus_err  (bus_err),
    .err_addr (err_addr)
  );

  // RAM device: 64 backed words, one-cycle registered read, preload port
  logic [31:0] dev_mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_addr;
  logic [31:0] pre_data;
  always @(posedge clk) begin
    if (pre_we) dev_mem[pre_addr] <= pre_data;
    else if (ram_en) begin
      if (ram_we) begin
        if (ram_addr[13:6] == 8'd0) dev_mem[ram_addr[5:0]] <= ram_wdata;
      end else ram_rdata <= dev_mem[ram_addr[5:0]];
    end
  end

  // Reference model state
  logic [31:0] mdl_mem [0:63];
  logic        mdl_err;
  logic [31:0] mdl_err_addr;
  logic [31:0] mdl_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_err = 1'b0; mdl_err_addr = '0; mdl_data = '0;
  endtask

  // One access. d = cycle of io_req in which io_ack is raised (0 = never).
  task automatic access(input logic [1:0] t, input logic [31:0] a, input logic [31:0] wd,
                        input int d, input logic [31:0] rd);
    bit is_ram, is_io, err;
    int lat, exp_ram, exp_io, c, ram_seen, io_seen;
    // model: plain range tests on the address map
    is_ram = (a < 32'h0001_0000);
    is_io  = (a >= 32'hFFFF_0000) && (a <= 32'hFFFF_0FFF);
    err = 0; exp_ram = 0; exp_io = 0; lat = 1;
    if (a % 4 != 0) err = 1;
    else if (is_ram) begin
      lat = 2; exp_ram = 1;
      if (a < 256) begin
        if (t == ACC_W) mdl_mem[a / 4] = wd;
        else mdl_data = mdl_mem[a / 4];
      end
    end else if (is_io && t != ACC_X) begin
      if (d >= 1 && d <= TMO) begin
        lat = d + 1; exp_io = d;
        if (t == ACC_R) mdl_data = rd;
      end else begin
        lat = TMO + 1; exp_io = TMO; err = 1;
      end
    end else err = 1;
    if (err) begin
      mdl_data = 0;
      if (!mdl_err) mdl_err_addr = a;
      mdl_err = 1;
    end

    bus.db_addr = a; bus.db_dataOut = wd; bus.db_accessType = t;
    c = 0; ram_seen = 0; io_seen = 0;
    #1;
    if (ram_en) begin
      ram_seen++;
      chk("ram_addr", {18'd0, ram_addr}, {18'd0, a[15:2]});
      chk("ram_we", {31'd0, ram_we}, {31'd0, t == ACC_W});
      if (t == ACC_W) chk("ram_wdata", ram_wdata, wd);
    end
    while (c < 40) begin
      @(posedge clk); #1;
      c++;
      io_ack   = (d != 0) && (c == d);
      io_rdata = io_ack ? rd : $urandom;
      if (ram_en) ram_seen++;
      if (io_req) begin
        io_seen++;
        if (c == 1) begin
          chk("io_addr", {20'd0, io_addr}, {20'd0, a[11:0]});
          chk("io_we", {31'd0, io_we}, {31'd0, t == ACC_W});
          if (t == ACC_W) chk("io_wdata", io_wdata, wd);
        end
      end
      if (bus.db_ready) break;
    end
    io_ack = 0;
    bus.db_accessType = ACC_NONE;
    chk("latency", c, lat);
    chk("ram_en_cycles", ram_seen, exp_ram);
    chk("io_req_cycles", io_seen, exp_io);
    chk("dataIn", bus.db_dataIn, mdl_data);
    chk("bus_err", {31'd0, bus_err}, {31'd0, mdl_err});
    chk("err_addr", err_addr, mdl_err_addr);
    @(posedge clk); #1;
    chk("ready_pulse", {31'd0, bus.db_ready}, 32'd0);
  endtask

  task automatic do_reset();
    res = 1'b0;
    mdl_reset();
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] v, a;
    int k;
    res = 1'b0;
    bus.db_addr = '0; bus.db_dataOut = '0; bus.db_accessType = ACC_NONE;
    io_ack = 1'b0; io_rdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    mdl_reset();

    // preload RAM and model with identical contents while in reset
    for (int i = 0; i < 64; i++) begin
      v = (i == 4) ? 32'hCAFE_0001 : $urandom;
      mdl_mem[i] = v;
      pre_we = 1'b1; pre_addr = 6'(i); pre_data = v;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;

    chk("rst_ready", {31'd0, bus.db_ready}, 32'd0);
    chk("rst_dataIn", bus.db_dataIn, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    chk("rst_io_req", {31'd0, io_req}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    res = 1'b1;
    @(posedge clk); #1;

    // T1 RAM read
    access(ACC_R, 32'h0000_0010, 32'd0, 0, 32'd0);
    chk("t1_data", bus.db_dataIn, 32'hCAFE_0001);
    // T2 RAM write, then read it back; data is unchanged by the write
    access(ACC_W, 32'h0000_0020, 32'h1234_5678, 0, 32'd0);
    chk("t2_data_held", bus.db_dataIn, 32'hCAFE_0001);
    access(ACC_R, 32'h0000_0020, 32'd0, 0, 32'd0);
    chk("t2_readback", bus.db_dataIn, 32'h1234_5678);
    // T3 MMIO read acked in the 5th cycle
    access(ACC_R, 32'hFFFF_0004, 32'd0, 5, 32'h0000_00A5);
    chk("t3_data", bus.db_dataIn, 32'h0000_00A5);
    // ack in the very last timeout cycle wins
    access(ACC_W, 32'hFFFF_0FFC, 32'h0BAD_F00D, TMO, 32'd0);
    chk("ack_at_tmo_no_err", {31'd0, bus_err}, 32'd0);
    // T4 MMIO timeout
    access(ACC_R, 32'hFFFF_0004, 32'd0, 0, 32'd0);
    chk("t4_err_addr", err_addr, 32'hFFFF_0004);

    // T5 unmapped then misaligned; first error address is kept
    do_reset();
    access(ACC_R, 32'h8000_0000, 32'd0, 0, 32'd0);
    access(ACC_X, 32'h0000_0002, 32'd0, 0, 32'd0);
    chk("t5_err_addr", err_addr, 32'h8000_0000);
    // window edges and X into MMIO
    access(ACC_W, 32'h0000_FFFC, 32'h5555_AAAA, 0, 32'd0);
    access(ACC_R, 32'h0001_0000, 32'd0, 0, 32'd0);
    access(ACC_X, 32'hFFFF_0010, 32'd0, 1, 32'h1);
    access(ACC_R, 32'hFFFF_1000, 32'd0, 1, 32'h1);
    chk("t5_err_addr_kept", err_addr, 32'h8000_0000);

    // T6 reset while an MMIO request is outstanding
    bus.db_addr = 32'hFFFF_0008; bus.db_accessType = ACC_R;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("t6_io_req_live", {31'd0, io_req}, 32'd1);
    res = 1'b0;
    #1;
    chk("t6_io_req", {31'd0, io_req}, 32'd0);
    chk("t6_ready", {31'd0, bus.db_ready}, 32'd0);
    chk("t6_bus_err", {31'd0, bus_err}, 32'd0);
    chk("t6_err_addr", err_addr, 32'd0);
    bus.db_accessType = ACC_NONE;
    mdl_reset();
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
    access(ACC_R, 32'h0000_0010, 32'd0, 0, 32'd0);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3, 4: a = 32'($urandom_range(0, 63)) * 4;
        5, 6, 7:       a = 32'hFFFF_0000 + 32'($urandom_range(0, 1023)) * 4;
        8:             a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
        default:       a = 32'h4000_0000 + 32'($urandom_range(0, 1023)) * 4;
      endcase
      access(2'($urandom_range(1, 3)), a, $urandom, $urandom_range(0, 10), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
